// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: two-requester round-robin arbiter that forwards one command
// word at a time to an SPI transmit stream, then routes received words and the
// end-of-transaction pulse back to the requester that owns the transaction.
module spi_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic [31:0] req0_data_i,
  input  logic [31:0] req1_data_i,
  input  logic [1:0]  req_vld_i,
  output logic [1:0]  req_rdy_o,
  output logic [31:0] rx_data_o,
  output logic [1:0]  rx_vld_o,
  output logic [1:0]  done_o,
  output logic [31:0] spi_data_o,
  output logic        spi_data_vld_o,
  input  logic        spi_data_rdy_i,
  input  logic [31:0] spi_data_rx_i,
  input  logic        spi_data_rx_vld_i,
  input  logic        eot_i,
  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_o
);

  // Counter must hold TIMEOUT itself without wrapping.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_EOT} state_t;

  state_t          state;
  logic            last;     // index of the requester granted most recently
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            to_hit;
  logic [1:0]      grant;
  logic [1:0]      owner_hot;

  // Round-robin grant, only offered while idle; the not-last requester wins ties.
  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      case (req_vld_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  assign req_rdy_o = grant;
  assign busy_o    = (state != IDLE);
  assign owner_hot = owner_o ? 2'b10 : 2'b01;
  assign cnt_nxt   = cnt + CW'(1);
  assign to_hit    = (TIMEOUT != 0) && (cnt_nxt == CW'(TIMEOUT));

  // Transaction FSM with registered outputs; rx/done/timeout are single-cycle pulses.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state          <= IDLE;
      last           <= 1'b1;
      cnt            <= '0;
      owner_o        <= 1'b0;
      spi_data_o     <= '0;
      spi_data_vld_o <= 1'b0;
      rx_data_o      <= '0;
      rx_vld_o       <= '0;
      done_o         <= '0;
      timeout_o      <= 1'b0;
    end else begin
      rx_vld_o  <= '0;
      done_o    <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != '0) begin
            owner_o        <= grant[1];
            last           <= grant[1];
            spi_data_o     <= grant[1] ? req1_data_i : req0_data_i;
            spi_data_vld_o <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (spi_data_rdy_i) begin
            spi_data_vld_o <= 1'b0;
            cnt            <= '0;
            state          <= WAIT_EOT;
          end
        end
        WAIT_EOT: begin
          if (spi_data_rx_vld_i) begin
            rx_data_o <= spi_data_rx_i;
            rx_vld_o  <= owner_hot;
          end
          // eot_i wins over a timeout expiring in the same cycle.
          if (eot_i) begin
            done_o <= owner_hot;
            state  <= IDLE;
          end else if (to_hit) begin
            timeout_o <= 1'b1;
            done_o    <= owner_hot;
            state     <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed testbench for spi_cmd_arbiter (TIMEOUT=8); each cycle the bench
// drives inputs 1ns after the rising edge and checks outputs 1ns later.
module tb_spi_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req0_data, req1_data;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  logic [31:0] rx_data;
  logic [1:0]  rx_vld;
  logic [1:0]  done;
  logic [31:0] spi_data;
  logic        spi_data_vld;
  logic        spi_data_rdy;
  logic [31:0] spi_data_rx;
  logic        spi_data_rx_vld;
  logic        eot;
  logic        busy;
  logic        owner;
  logic        timeout;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  spi_cmd_arbiter #(.TIMEOUT(8)) dut (
    .pclk_i            (clk),
    .prst_i            (rst),
    .req0_data_i       (req0_data),
    .req1_data_i       (req1_data),
    .req_vld_i         (req_vld),
    .req_rdy_o         (req_rdy),
    .rx_data_o         (rx_data),
    .rx_vld_o          (rx_vld),
    .done_o            (done),
    .spi_data_o        (spi_data),
    .spi_data_vld_o    (spi_data_vld),
    .spi_data_rdy_i    (spi_data_rdy),
    .spi_data_rx_i     (spi_data_rx),
    .spi_data_rx_vld_i (spi_data_rx_vld),
    .eot_i             (eot),
    .busy_o            (busy),
    .owner_o           (owner),
    .timeout_o         (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle: rising edge plus 1ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0_data = '0; req1_data = '0; req_vld = '0;
    spi_data_rdy = 1'b0; spi_data_rx = '0; spi_data_rx_vld = 1'b0; eot = 1'b0;
    tick(); tick();

    // Reset state, then single transaction from requester 0.
    rst = 1'b0;
    #1;
    check("rst_spi_data", spi_data, 32'h0);
    check("rst_spi_vld", {31'b0, spi_data_vld}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_outs", {rx_data[15:0], 8'h0, rx_vld, done, owner, timeout, 2'b0}, 32'h0);
    req_vld = 2'b01; req0_data = 32'h1234_5678; spi_data_rdy = 1'b1;
    #1;
    check("t1_rdy_N", {30'b0, req_rdy}, 32'h1);
    tick();
    req_vld = 2'b00;
    #1;
    check("t1_vld_N1", {31'b0, spi_data_vld}, 32'h1);
    check("t1_data_N1", spi_data, 32'h1234_5678);
    check("t1_busy", {31'b0, busy}, 32'h1);
    check("t1_rdy_issue", {30'b0, req_rdy}, 32'h0);
    tick();
    eot = 1'b1;
    #1;
    check("t1_vld_drop", {31'b0, spi_data_vld}, 32'h0);
    tick();
    eot = 1'b0;
    #1;
    check("t1_done", {30'b0, done}, 32'h1);
    check("t1_idle", {31'b0, busy}, 32'h0);
    tick();
    check("t1_done_pulse", {30'b0, done}, 32'h0);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    rst = 1'b1; tick(); rst = 1'b0;
    req0_data = 32'hA000_0000; req1_data = 32'hB000_0001;
    req_vld = 2'b11; spi_data_rdy = 1'b1; eot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy", {30'b0, req_rdy}, (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (i == 3) req_vld = 2'b00;
      #1;
      check("rr_owner", {31'b0, owner}, (i % 2 == 0) ? 32'h0 : 32'h1);
      check("rr_data", spi_data, (i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0001);
      tick();
      tick();
      check("rr_done", {30'b0, done}, (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    eot = 1'b0;

    // Backpressure: data held stable for 5 cycles, inputs changing underneath.
    req_vld = 2'b10; req1_data = 32'h3ABC_DEF0; spi_data_rdy = 1'b0;
    #1;
    check("bp_rdy", {30'b0, req_rdy}, 32'h2);
    tick();
    req_vld = 2'b01; req0_data = 32'hDEAD_BEEF; req1_data = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_vld", {31'b0, spi_data_vld}, 32'h1);
      check("bp_data", spi_data, 32'h3ABC_DEF0);
      check("bp_rdy0", {30'b0, req_rdy}, 32'h0);
      tick();
    end
    spi_data_rdy = 1'b1; req_vld = 2'b00;
    tick();

    // WAIT_EOT owner 1: rx word together with eot.
    spi_data_rx = 32'hCAFE_F00D; spi_data_rx_vld = 1'b1; eot = 1'b1;
    tick();
    spi_data_rx_vld = 1'b0; eot = 1'b0;
    #1;
    check("rxeot_rxvld", {30'b0, rx_vld}, 32'h2);
    check("rxeot_data", rx_data, 32'hCAFE_F00D);
    check("rxeot_done", {30'b0, done}, 32'h2);

    // rx/eot while idle are dropped.
    spi_data_rx = 32'h1111_1111; spi_data_rx_vld = 1'b1; eot = 1'b1;
    tick();
    spi_data_rx_vld = 1'b0; eot = 1'b0;
    #1;
    check("idle_rxvld", {30'b0, rx_vld}, 32'h0);
    check("idle_done", {30'b0, done}, 32'h0);
    check("idle_rxdata", rx_data, 32'hCAFE_F00D);

    // Timeout after 8 cycles in WAIT_EOT; mid-wait rx forwarded; late eot ignored.
    req_vld = 2'b01; req0_data = 32'h0F0F_0F0F; spi_data_rdy = 1'b1;
    tick();
    req_vld = 2'b00;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin spi_data_rx = 32'h5555_AAAA; spi_data_rx_vld = 1'b1; end
      else spi_data_rx_vld = 1'b0;
      #1;
      check("to_wait_to", {31'b0, timeout}, 32'h0);
      check("to_wait_done", {30'b0, done}, 32'h0);
      check("to_wait_busy", {31'b0, busy}, 32'h1);
      if (i == 4) begin
        check("to_rx_vld", {30'b0, rx_vld}, 32'h1);
        check("to_rx_data", rx_data, 32'h5555_AAAA);
      end
      tick();
    end
    spi_data_rx_vld = 1'b0;
    eot = 1'b1;
    #1;
    check("to_pulse", {31'b0, timeout}, 32'h1);
    check("to_done", {30'b0, done}, 32'h1);
    tick();
    eot = 1'b0;
    #1;
    check("to_busy_after", {31'b0, busy}, 32'h0);
    check("to_late_done", {30'b0, done}, 32'h0);
    check("to_late_to", {31'b0, timeout}, 32'h0);

    // Reset mid-transaction: no done, outputs cleared, requester 0 wins next.
    req_vld = 2'b01; req0_data = 32'h7777_8888;
    tick();
    req_vld = 2'b00;
    tick();
    rst = 1'b1; eot = 1'b1; spi_data_rx = 32'h9999_0000; spi_data_rx_vld = 1'b1;
    tick();
    rst = 1'b0; eot = 1'b0; spi_data_rx_vld = 1'b0;
    #1;
    check("mrst_busy", {31'b0, busy}, 32'h0);
    check("mrst_done", {30'b0, done}, 32'h0);
    check("mrst_rxvld", {30'b0, rx_vld}, 32'h0);
    check("mrst_spi_data", spi_data, 32'h0);
    check("mrst_rx_data", rx_data, 32'h0);
    check("mrst_spi_vld", {31'b0, spi_data_vld}, 32'h0);
    req_vld = 2'b11;
    #1;
    check("mrst_grant", {30'b0, req_rdy}, 32'h1);
    tick();
    req_vld = 2'b00;
    #1;
    check("mrst_owner", {31'b0, owner}, 32'h0);
    check("mrst_data", spi_data, 32'h7777_8888);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
